// File: rtl/sti_dac.sv
// sti_dac: serial transmitter plus data arrangement controller.
// Each accepted load is framed into a 32-bit word and shifted out as
// 8/16/24/32 bits on so_data/so_valid. The serial stream is packed into
// pixel bytes that are scattered in a checkerboard over four odd and four
// even 32-byte memories. After pi_end, the image is zero-padded to 256
// pixels and oem_finish is raised.
// Optional feature macro: PIXEL_OUT_EN (adds the pixel_* debug outputs).
module sti_dac (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] pi_data,
  input  logic [1:0]  pi_length,
  input  logic        pi_fill,
  input  logic        pi_msb,
  input  logic        pi_low,
  input  logic        pi_end,
  output logic        so_data,
  output logic        so_valid,
  output logic        oem_finish,
  output logic [4:0]  oem_addr,
  output logic [7:0]  oem_dataout,
  output logic        odd1_wr,
  output logic        odd2_wr,
  output logic        odd3_wr,
  output logic        odd4_wr,
  output logic        even1_wr,
  output logic        even2_wr,
  output logic        even3_wr,
  output logic        even4_wr
`ifdef PIXEL_OUT_EN
  ,
  output logic        pixel_wr,
  output logic [7:0]  pixel_addr,
  output logic [7:0]  pixel_dataout,
  output logic        pixel_finish
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_PAD  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;

  // Serializer state
  logic [31:0] shift_w;
  logic [4:0]  bit_idx;     // index of the next bit to put on so_data
  logic [4:0]  bits_left;   // bits still to send after the one on so_data
  logic        msb_first;

  // Packer / writer state
  logic [6:0]  pix_sr;      // first 7 bits of the pixel being assembled
  logic [2:0]  bit_cnt;
  logic [8:0]  pix_n;       // pixels written so far; bit 8 set means full
  logic [7:0]  wr_vec;      // {even4..even1, odd4..odd1}

  logic [31:0] frame_w;
  logic [4:0]  last_idx;

  assign {even4_wr, even3_wr, even2_wr, even1_wr,
          odd4_wr,  odd3_wr,  odd2_wr,  odd1_wr} = wr_vec;

  // N-1 for N = 8/16/24/32 is simply the length code followed by 3'b111.
  assign last_idx = {pi_length, 3'b111};

  // One-hot strobe for pixel n: memory n[7:6], odd when row and column
  // parities match (row[0] = n[4], col[0] = n[0]).
  function automatic logic [7:0] strobe_for(input logic [7:0] n);
    logic [7:0] v;
    v = '0;
    if (n[4] == n[0]) v[{1'b0, n[7:6]}] = 1'b1;
    else              v[{1'b1, n[7:6]}] = 1'b1;
    return v;
  endfunction

  // Frame the parallel word according to length and fill controls.
  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    frame_w = '0;
    case (pi_length)
      2'b00:   frame_w[7:0]  = pi_low ? pi_data[15:8] : pi_data[7:0];
      2'b01:   frame_w[15:0] = pi_data;
      2'b10:   frame_w[23:0] = pi_fill ? {pi_data, 8'h00} : {8'h00, pi_data};
      default: frame_w       = pi_fill ? {pi_data, 16'h0000} : {16'h0000, pi_data};
    endcase
  end

  // Control FSM and serializer: one bit per cycle while in SEND.
  // NOTE: reset is asynchronous, so a mid-stream reset clears outputs at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      so_valid   <= 1'b0;
      so_data    <= 1'b0;
      shift_w    <= '0;
      bit_idx    <= '0;
      bits_left  <= '0;
      msb_first  <= 1'b0;
      oem_finish <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in step.
      case (state)
        S_IDLE: begin
          if (load) begin
            shift_w   <= frame_w;
            msb_first <= pi_msb;
            so_valid  <= 1'b1;
            so_data   <= frame_w[pi_msb ? last_idx : 5'd0];
            bit_idx   <= pi_msb ? (last_idx - 5'd1) : 5'd1;
            bits_left <= last_idx;
            state     <= S_SEND;
          end else if (pi_end) begin
            state <= S_PAD;
          end
        end
        S_SEND: begin
          if (bits_left != 5'd0) begin
            so_data   <= shift_w[bit_idx];
            bit_idx   <= msb_first ? (bit_idx - 5'd1) : (bit_idx + 5'd1);
            bits_left <= bits_left - 5'd1;
          end else begin
            // Returning to IDLE here guarantees so_valid is low for a cycle
            // before the next load can be sampled.
            so_valid <= 1'b0;
            so_data  <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_PAD: begin
          // Finish once the 256th strobe has already dropped.
          if (wr_vec == 8'h00 && pix_n[8]) begin
            oem_finish <= 1'b1;
            state      <= S_DONE;
          end
        end
        default: ; // S_DONE holds until reset
      endcase
    end
  end

  // Pack serial bits into pixels and issue memory writes (stream or padding).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_vec      <= '0;
      oem_addr    <= '0;
      oem_dataout <= '0;
      pix_sr      <= '0;
      bit_cnt     <= '0;
      pix_n       <= '0;
`ifdef PIXEL_OUT_EN
      pixel_wr      <= 1'b0;
      pixel_addr    <= '0;
      pixel_dataout <= '0;
`endif
    end else begin
      // Strobes last one cycle; the low cycle after gives each write a fresh edge.
      wr_vec <= '0;
`ifdef PIXEL_OUT_EN
      pixel_wr <= 1'b0;
`endif
      if (so_valid) begin
        pix_sr  <= {pix_sr[5:0], so_data};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7 && !pix_n[8]) begin
          wr_vec      <= strobe_for(pix_n[7:0]);
          oem_addr    <= pix_n[5:1];
          oem_dataout <= {pix_sr, so_data};
          pix_n       <= pix_n + 9'd1;
`ifdef PIXEL_OUT_EN
          pixel_wr      <= 1'b1;
          pixel_addr    <= pix_n[7:0];
          pixel_dataout <= {pix_sr, so_data};
`endif
        end
      end else if (state == S_PAD && wr_vec == 8'h00 && !pix_n[8]) begin
        // Any partial byte left in pix_sr is simply never written.
        wr_vec      <= strobe_for(pix_n[7:0]);
        oem_addr    <= pix_n[5:1];
        oem_dataout <= 8'h00;
        pix_n       <= pix_n + 9'd1;
      end
    end
  end

`ifdef PIXEL_OUT_EN
  assign pixel_finish = oem_finish;
`endif

endmodule

// File: tb/tb_sti_dac.sv
// Self-checking bench for sti_dac: a bit-level model of the serial stream
// and pixel placement, compared against the DUT every clock cycle.
module tb_sti_dac;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        pi_fill, pi_msb, pi_low, pi_end;
  logic        so_data, so_valid, oem_finish;
  logic [4:0]  oem_addr;
  logic [7:0]  oem_dataout;
  logic        odd1_wr, odd2_wr, odd3_wr, odd4_wr;
  logic        even1_wr, even2_wr, even3_wr, even4_wr;

  sti_dac dut (
    .clk(clk), .reset(reset), .load(load), .pi_data(pi_data),
    .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb),
    .pi_low(pi_low), .pi_end(pi_end), .so_data(so_data),
    .so_valid(so_valid), .oem_finish(oem_finish), .oem_addr(oem_addr),
    .oem_dataout(oem_dataout),
    .odd1_wr(odd1_wr), .odd2_wr(odd2_wr), .odd3_wr(odd3_wr), .odd4_wr(odd4_wr),
    .even1_wr(even1_wr), .even2_wr(even2_wr), .even3_wr(even3_wr),
    .even4_wr(even4_wr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected serial bits, written only by the driver.
  logic exp_bits [0:4095];
  int   n_push   = 0;
  bit   end_sent = 0;

  // Compare-process state.
  int         cyc = 0, rd_idx = 0, n_exp = 0, bits_seen = 0, pad_cnt = 0;
  int         last_wr_cyc = -1, prev_wr_cyc = -10;
  bit         pend = 0, prev_pad = 0;
  logic [7:0] cur = 0;
  logic [7:0] log_vec  [0:255];
  logic [4:0] log_addr [0:255];
  logic [7:0] log_data [0:255];

  function automatic logic [7:0] dut_wr();
    return {even4_wr, even3_wr, even2_wr, even1_wr,
            odd4_wr, odd3_wr, odd2_wr, odd1_wr};
  endfunction

  // Expected strobe vector for pixel n from row/column arithmetic.
  function automatic logic [7:0] exp_vec(input int n);
    int k, row, col;
    logic [7:0] v;
    k = n / 64; row = n / 16; col = n % 16;
    v = '0;
    if ((row % 2) == (col % 2)) v[k] = 1'b1;
    else                        v[4 + k] = 1'b1;
    return v;
  endfunction

  // Per-cycle comparison of serial stream, writes and finish flag.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        rd_idx = 0; n_exp = 0; bits_seen = 0; pad_cnt = 0;
        last_wr_cyc = -1; prev_wr_cyc = -10; pend = 0; prev_pad = 0; cur = 0;
      end else begin
        if (pend) begin
          check("stream_wr_vec", dut_wr(), exp_vec(n_exp));
          check("stream_addr", oem_addr, (n_exp % 64) / 2);
          check("stream_data", oem_dataout, cur);
          log_vec[n_exp] = dut_wr(); log_addr[n_exp] = oem_addr;
          log_data[n_exp] = oem_dataout;
          prev_wr_cyc = cyc; prev_pad = 0; pend = 0;
          n_exp++;
          if (n_exp == 256) last_wr_cyc = cyc;
        end else if (dut_wr() != 8'h00) begin
          check("pad_allowed", end_sent && n_exp < 256, 1);
          if (n_exp < 256) begin
            check("pad_wr_vec", dut_wr(), exp_vec(n_exp));
            check("pad_addr", oem_addr, (n_exp % 64) / 2);
            check("pad_data", oem_dataout, 0);
            if (prev_pad) check("pad_cadence", cyc - prev_wr_cyc, 2);
            else          check("pad_first_gap", (cyc - prev_wr_cyc) >= 2, 1);
            log_vec[n_exp] = dut_wr(); log_addr[n_exp] = oem_addr;
            log_data[n_exp] = oem_dataout;
            prev_wr_cyc = cyc; prev_pad = 1; pad_cnt++;
            n_exp++;
            if (n_exp == 256) last_wr_cyc = cyc;
          end
        end
        check("oem_finish", oem_finish, (last_wr_cyc >= 0 && cyc >= last_wr_cyc + 2));
        if (so_valid) begin
          if (rd_idx < n_push) begin
            check("so_data", so_data, exp_bits[rd_idx]);
            cur = {cur[6:0], exp_bits[rd_idx]};
          end else begin
            check("so_valid_extra", so_valid, 0);
          end
          rd_idx++;
          bits_seen++;
          if (bits_seen % 8 == 0 && n_exp < 256) pend = 1;
        end else begin
          check("so_data_idle", so_data, 0);
        end
      end
    end
  end

  // Push the model's bit sequence for one load.
  task automatic push_bits(input logic [15:0] d, input logic [1:0] len,
                           input logic fill, input logic msb, input logic low,
                           output int nb);
    logic [31:0] w;
    nb = 8 * (int'(len) + 1);
    case (len)
      2'd0:    w = {24'h0, (low ? d[15:8] : d[7:0])};
      2'd1:    w = {16'h0, d};
      2'd2:    w = fill ? {8'h0, d, 8'h0} : {16'h0, d};
      default: w = fill ? {d, 16'h0} : {16'h0, d};
    endcase
    for (int i = 0; i < nb; i++) begin
      exp_bits[n_push] = msb ? w[nb - 1 - i] : w[i];
      n_push++;
    end
  endtask

  // Issue one load at the current negedge and follow it to completion.
  task automatic do_load(input logic [15:0] d, input logic [1:0] len,
                         input logic fill, input logic msb, input logic low,
                         input bit poke, output logic [31:0] cap);
    int nb;
    push_bits(d, len, fill, msb, low, nb);
    pi_data = d; pi_length = len; pi_fill = fill; pi_msb = msb; pi_low = low;
    load = 1'b1;
    cap = '0;
    @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      if (i > 0) @(negedge clk);
      check("so_valid_on", so_valid, 1);
      cap = {cap[30:0], so_data};
      load = (poke && i == 2);
      if (load) pi_data = ~d;
    end
    load = 1'b0;
    @(negedge clk);
    check("so_valid_off", so_valid, 0);
  endtask

  logic [31:0] cap;
  int          units [0:93];

  initial begin
    reset = 1'b1; load = 1'b0; pi_data = '0; pi_length = '0;
    pi_fill = 1'b0; pi_msb = 1'b0; pi_low = 1'b0; pi_end = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_so_valid", so_valid, 0);
    check("rst_so_data", so_data, 0);
    check("rst_finish", oem_finish, 0);
    check("rst_wr", dut_wr(), 0);
    check("rst_addr", oem_addr, 0);
    check("rst_data", oem_dataout, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed words: routing pixels then the 8- and 32-bit framing cases.
    do_load(16'h1122, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, cap);
    do_load(16'h3344, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, cap);
    do_load(16'hA55A, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, cap);
    check("bits8_msb_high", cap[7:0], 8'hA5);
    do_load(16'hA55A, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, cap);
    check("bits8_lsb_low", cap[7:0], 8'h5A);
    do_load(16'h8001, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, cap);
    check("bits32_fill1", cap, 32'h8001_0000);
    do_load(16'h8001, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, cap);
    check("bits32_fill0", cap, 32'h0000_8001);

    // 94 random loads totalling 1760 bits (220 byte units).
    for (int i = 0; i < 94; i++) units[i] = 1;
    for (int extra = 126; extra > 0; ) begin
      int j;
      j = int'($urandom_range(93, 0));
      if (units[j] < 4) begin
        units[j]++;
        extra--;
      end
    end
    for (int i = 0; i < 94; i++) begin
      do_load(16'($urandom), 2'(units[i] - 1), 1'($urandom), 1'($urandom),
              1'($urandom), (i % 7 == 0), cap);
    end
    check("bits_streamed", bits_seen, 1872);

    pi_end = 1'b1;
    end_sent = 1;
    for (int i = 0; i < 3000 && !oem_finish; i++) @(negedge clk);
    check("finish_reached", oem_finish, 1);
    @(negedge clk);
    check("pixels_written", n_exp, 256);
    check("pad_writes", pad_cnt, 22);
    check("px0_vec", log_vec[0], 8'h01);   check("px0_addr", log_addr[0], 0);
    check("px0_data", log_data[0], 8'h11);
    check("px1_vec", log_vec[1], 8'h10);   check("px1_addr", log_addr[1], 0);
    check("px1_data", log_data[1], 8'h22);
    check("px2_vec", log_vec[2], 8'h01);   check("px2_addr", log_addr[2], 1);
    check("px2_data", log_data[2], 8'h33);
    check("px3_vec", log_vec[3], 8'h10);   check("px3_addr", log_addr[3], 1);
    check("px3_data", log_data[3], 8'h44);
    check("px16_vec", log_vec[16], 8'h10); check("px16_addr", log_addr[16], 8);
    check("px17_vec", log_vec[17], 8'h01); check("px17_addr", log_addr[17], 8);
    check("px254_vec", log_vec[254], 8'h80); check("px254_addr", log_addr[254], 31);
    check("px255_vec", log_vec[255], 8'h08); check("px255_addr", log_addr[255], 31);
    check("px255_data", log_data[255], 8'h00);
    repeat (20) @(negedge clk);
    check("finish_held", oem_finish, 1);

    // Reset while finished clears oem_finish immediately.
    #2 reset = 1'b1; n_push = 0; end_sent = 0; pi_end = 1'b0;
    #1 check("rst_clears_finish", oem_finish, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);

    // Reset during a stream, exactly while a write strobe is high.
    do_load(16'hFFFF, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, cap);
    begin
      int nb;
      push_bits(16'h1234, 2'd3, 1'b1, 1'b1, 1'b0, nb);
      pi_data = 16'h1234; pi_length = 2'd3; pi_fill = 1'b1; pi_msb = 1'b1;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (8) @(negedge clk);
    end
    check("pre_reset_valid", so_valid, 1);
    check("pre_reset_strobe", |dut_wr(), 1);
    #2 reset = 1'b1; n_push = 0;
    #1;
    check("mid_rst_valid", so_valid, 0);
    check("mid_rst_data", so_data, 0);
    check("mid_rst_wr", dut_wr(), 0);
    check("mid_rst_finish", oem_finish, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    do_load(16'h5A3C, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, cap);
    @(negedge clk);
    check("restart_px0_vec", log_vec[0], 8'h01);
    check("restart_px0_addr", log_addr[0], 0);
    check("restart_px0_data", log_data[0], 8'h5A);
    check("restart_px1_vec", log_vec[1], 8'h10);
    check("restart_px1_data", log_data[1], 8'h3C);
    check("restart_count", n_exp, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
